// File: rtl/alu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_sequencer_pkg
// Shared definitions for the ALU sequencer:
//   - ALU_* opcode encodings (4-bit). Codes 4'hC..4'hF are undefined.
//   - Flag bit indices inside the 4-bit flags word.
//   - FSM state encodings.
//   - Opcode class enum and decode helpers is_reg_form / is_imm_form / is_cm_form.
// ---------------------------------------------------------------------------
package alu_sequencer_pkg;

    // Register-form operations: y operand comes from the register file.
    localparam logic [3:0] ALU_SUM = 4'h0;
    localparam logic [3:0] ALU_SB  = 4'h1;
    localparam logic [3:0] ALU_ANR = 4'h2;
    localparam logic [3:0] ALU_ORR = 4'h3;
    localparam logic [3:0] ALU_XRR = 4'h4;
    // Immediate-form operations: y operand is the instruction immediate.
    localparam logic [3:0] ALU_SMI = 4'h5;
    localparam logic [3:0] ALU_SBI = 4'h6;
    localparam logic [3:0] ALU_ANI = 4'h7;
    localparam logic [3:0] ALU_ORI = 4'h8;
    localparam logic [3:0] ALU_XRI = 4'h9;
    // Complement: y operand is forced to zero.
    localparam logic [3:0] ALU_CM  = 4'hA;
    localparam logic [3:0] ALU_CMI = 4'hB;

    // Flag bit positions (bit 3 is passed through from the ALU unchanged).
    localparam int CARRY_FLAG = 0;
    localparam int NEG_FLAG   = 1;
    localparam int ZERO_FLAG  = 2;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;

    typedef enum logic [1:0] {
        OP_CLASS_REG     = 2'd0,
        OP_CLASS_IMM     = 2'd1,
        OP_CLASS_CM      = 2'd2,
        OP_CLASS_ILLEGAL = 2'd3
    } op_class_e;

    function automatic logic is_reg_form(input logic [3:0] op);
        return (op == ALU_SUM) || (op == ALU_SB) || (op == ALU_ANR) ||
               (op == ALU_ORR) || (op == ALU_XRR);
    endfunction

    function automatic logic is_imm_form(input logic [3:0] op);
        return (op == ALU_SMI) || (op == ALU_SBI) || (op == ALU_ANI) ||
               (op == ALU_ORI) || (op == ALU_XRI);
    endfunction

    function automatic logic is_cm_form(input logic [3:0] op);
        return (op == ALU_CM) || (op == ALU_CMI);
    endfunction

endpackage : alu_sequencer_pkg

// File: rtl/alu_sequencer_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Combinational classifier for an incoming ALU opcode.
// Ports:
//   i_op     in  4  opcode offered by the decoder
//   o_class  out 2  register / immediate / complement / illegal
// ---------------------------------------------------------------------------
module alu_op_decode
    import alu_sequencer_pkg::*;
(
    input  logic [3:0] i_op,
    output op_class_e  o_class
);

    always_comb begin
        // NOTE: default assignment first so every path drives o_class and no latch is inferred.
        o_class = OP_CLASS_ILLEGAL;
        if (is_reg_form(i_op)) begin
            o_class = OP_CLASS_REG;
        end else if (is_imm_form(i_op)) begin
            o_class = OP_CLASS_IMM;
        end else if (is_cm_form(i_op)) begin
            o_class = OP_CLASS_CM;
        end
    end

endmodule : alu_op_decode

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Control FSM (IDLE -> [READ] -> EXEC -> IDLE) that sequences the 8-bit ALU
// for one instruction at a time. Owns the accumulator and the flags register;
// the accumulator is always the ALU x operand.
//
// Build option: ALU_ZERO_FLAG_EN -- when defined, flags[ZERO_FLAG] is written
// with (alu_out == 0) instead of the ALU's own zero bit.
//
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   instr_valid/instr_ready      instruction handshake (ready only in IDLE)
//   instr_op/instr_reg/instr_imm decoded instruction fields
//   rf_rd_en/rf_rd_addr          register-file read request (in READ)
//   rf_rd_data                   read data, valid the cycle after rf_rd_en
//   alu_x/alu_y/alu_operation    ALU operands/op (non-zero only in EXEC)
//   alu_out/alu_flags            combinational ALU result and flags
//   acc_wr_en/acc_wr_data        direct accumulator load (IDLE, no accept)
//   acc_out/flags_out            accumulator and flags registers
//   done/illegal                 one-cycle retire pulse / undefined opcode
// ---------------------------------------------------------------------------
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int RF_ADDR_W = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [3:0]           instr_op,
    input  logic [RF_ADDR_W-1:0] instr_reg,
    input  logic [7:0]           instr_imm,
    output logic                 rf_rd_en,
    output logic [RF_ADDR_W-1:0] rf_rd_addr,
    input  logic [7:0]           rf_rd_data,
    output logic [7:0]           alu_x,
    output logic [7:0]           alu_y,
    output logic [3:0]           alu_operation,
    input  logic [7:0]           alu_out,
    input  logic [3:0]           alu_flags,
    input  logic                 acc_wr_en,
    input  logic [7:0]           acc_wr_data,
    output logic [7:0]           acc_out,
    output logic [3:0]           flags_out,
    output logic                 done,
    output logic                 illegal
);

    logic [1:0]           r_state;
    logic [3:0]           r_op;
    logic [RF_ADDR_W-1:0] r_reg;
    logic [7:0]           r_imm;
    op_class_e            r_class;
    logic [7:0]           r_acc;
    logic [3:0]           r_flags;
    logic                 r_done;
    logic                 r_illegal;

    op_class_e            w_class;
    logic                 w_accept;
    logic [3:0]           w_flags_next;

    alu_op_decode u_decode (
        .i_op    (instr_op),
        .o_class (w_class)
    );

    // Ready depends on state alone so the decoder never sees a combinational
    // path from its own valid back to ready.
    assign instr_ready = (r_state == ST_IDLE);
    assign w_accept    = instr_valid && instr_ready;

    assign rf_rd_en    = (r_state == ST_READ);
    assign rf_rd_addr  = r_reg;

    assign acc_out     = r_acc;
    assign flags_out   = r_flags;
    assign done        = r_done;
    assign illegal     = r_illegal;

    // Operand mux: quiet (all zero) outside EXEC.
    always_comb begin
        alu_x         = '0;
        alu_y         = '0;
        alu_operation = '0;
        if (r_state == ST_EXEC) begin
            alu_x         = r_acc;
            alu_operation = r_op;
            case (r_class)
                OP_CLASS_REG: alu_y = rf_rd_data;
                OP_CLASS_IMM: alu_y = r_imm;
                default:      alu_y = '0;
            endcase
        end
    end

    always_comb begin
        w_flags_next = alu_flags;
`ifdef ALU_ZERO_FLAG_EN
        w_flags_next[ZERO_FLAG] = (alu_out == 8'h00);
`endif
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_reg     <= '0;
            r_imm     <= '0;
            r_class   <= OP_CLASS_REG;
            r_acc     <= '0;
            r_flags   <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= instr_op;
                        r_reg   <= instr_reg;
                        r_imm   <= instr_imm;
                        r_class <= w_class;
                        case (w_class)
                            OP_CLASS_REG: r_state <= ST_READ;
                            OP_CLASS_IMM,
                            OP_CLASS_CM:  r_state <= ST_EXEC;
                            default: begin
                                // Undefined opcode retires at once without
                                // touching acc or flags.
                                r_done    <= 1'b1;
                                r_illegal <= 1'b1;
                            end
                        endcase
                    end else if (acc_wr_en) begin
                        r_acc <= acc_wr_data;
                    end
                end
                ST_READ: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_acc   <= alu_out;
                    r_flags <= w_flags_next;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : alu_sequencer

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer. Provides a behavioural ALU and a
// registered 8-entry register file; expected retire results are pushed to a
// scoreboard queue on accept and popped when done is observed.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int RF_ADDR_W = 3;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 instr_valid = 1'b0;
    logic                 instr_ready;
    logic [3:0]           instr_op = '0;
    logic [RF_ADDR_W-1:0] instr_reg = '0;
    logic [7:0]           instr_imm = '0;
    logic                 rf_rd_en;
    logic [RF_ADDR_W-1:0] rf_rd_addr;
    logic [7:0]           rf_rd_data = '0;
    logic [7:0]           alu_x;
    logic [7:0]           alu_y;
    logic [3:0]           alu_operation;
    logic [7:0]           alu_out;
    logic [3:0]           alu_flags;
    logic                 acc_wr_en = 1'b0;
    logic [7:0]           acc_wr_data = '0;
    logic [7:0]           acc_out;
    logic [3:0]           flags_out;
    logic                 done;
    logic                 illegal;

    alu_sequencer #(.RF_ADDR_W(RF_ADDR_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_reg     (instr_reg),
        .instr_imm     (instr_imm),
        .rf_rd_en      (rf_rd_en),
        .rf_rd_addr    (rf_rd_addr),
        .rf_rd_data    (rf_rd_data),
        .alu_x         (alu_x),
        .alu_y         (alu_y),
        .alu_operation (alu_operation),
        .alu_out       (alu_out),
        .alu_flags     (alu_flags),
        .acc_wr_en     (acc_wr_en),
        .acc_wr_data   (acc_wr_data),
        .acc_out       (acc_out),
        .flags_out     (flags_out),
        .done          (done),
        .illegal       (illegal)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural ALU and register file ----------------
    // Returns {flags[3:0], result[7:0]}; flags = {0, zero, neg, carry}.
    function automatic logic [11:0] alu_model(input logic [3:0] op,
                                              input logic [7:0] x,
                                              input logic [7:0] y);
        logic [8:0] wide;
        logic [7:0] r;
        logic       c;
        wide = '0;
        r    = '0;
        c    = 1'b0;
        case (op)
            ALU_SUM, ALU_SMI: begin wide = {1'b0, x} + {1'b0, y}; r = wide[7:0]; c = wide[8]; end
            ALU_SB,  ALU_SBI: begin wide = {1'b0, x} - {1'b0, y}; r = wide[7:0]; c = wide[8]; end
            ALU_ANR, ALU_ANI: r = x & y;
            ALU_ORR, ALU_ORI: r = x | y;
            ALU_XRR, ALU_XRI: r = x ^ y;
            ALU_CM,  ALU_CMI: r = ~x;
            default:          r = 8'h00;
        endcase
        return {1'b0, (r == 8'h00), r[7], c, r};
    endfunction

    always_comb {alu_flags, alu_out} = alu_model(alu_operation, alu_x, alu_y);

    logic [7:0] rf_mem [8];
    always @(posedge clock) begin
        if (rf_rd_en) rf_rd_data <= rf_mem[rf_rd_addr];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] acc;
        logic [3:0] flags;
        logic       illegal;
        int         due;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_done = 0;
    logic [7:0] m_acc = '0;
    logic [3:0] m_flags = '0;

    always @(posedge clock) cyc <= cyc + 1;

    // Outputs are sampled on the falling edge, well away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("retire_acc",     acc_out,   mon_e.acc);
                    check("retire_flags",   flags_out, mon_e.flags);
                    check("retire_illegal", illegal,   mon_e.illegal);
                    check("retire_cycle",   cyc,       mon_e.due);
                end
            end else if (illegal) begin
                check("illegal_without_done", 32'd1, 32'd0);
            end
        end
    end

    // Offers one instruction, waits (bounded) for ready, and on acceptance
    // pushes the expected retire result. Returns at accept edge + 1.
    task automatic send(input logic [3:0] op, input logic [2:0] rg,
                        input logic [7:0] imm, output int acc_cyc);
        int         budget;
        int         lat;
        logic [7:0] y;
        logic [11:0] res;
        exp_t       e;
        budget = 0;
        instr_valid = 1'b1;
        instr_op    = op;
        instr_reg   = rg;
        instr_imm   = imm;
        while (!instr_ready && budget < 20) begin
            @(posedge clock); #1;
            budget++;
        end
        if (!instr_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
            acc_cyc = cyc;
            return;
        end
        @(posedge clock); #1;
        instr_valid = 1'b0;
        acc_cyc = cyc;
        if (op <= ALU_XRR) begin
            y = rf_mem[rg]; lat = 2;
        end else if (op <= ALU_XRI) begin
            y = imm;        lat = 1;
        end else if (op <= ALU_CMI) begin
            y = 8'h00;      lat = 1;
        end else begin
            y = 8'h00;      lat = 0;
        end
        if (lat == 0) begin
            e.acc = m_acc; e.flags = m_flags; e.illegal = 1'b1;
        end else begin
            res = alu_model(op, m_acc, y);
`ifdef ALU_ZERO_FLAG_EN
            res[8 + ZERO_FLAG] = (res[7:0] == 8'h00);
`endif
            e.acc = res[7:0]; e.flags = res[11:8]; e.illegal = 1'b0;
            m_acc = res[7:0]; m_flags = res[11:8];
        end
        e.due = acc_cyc + lat;
        sb.push_back(e);
    endtask

    task automatic load(input logic [7:0] v);
        acc_wr_en   = 1'b1;
        acc_wr_data = v;
        @(posedge clock); #1;
        acc_wr_en = 1'b0;
        m_acc = v;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 30) begin
            @(posedge clock); #1;
            budget++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random stimulus ----------------
    initial begin
        int c1, c2, d0;
        logic [3:0] f_before;

        for (int i = 0; i < 8; i++) rf_mem[i] = 8'(8'h10 * i + 1);
        rf_mem[2] = 8'h20;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_acc",     acc_out,     32'h0);
        check("rst_flags",   flags_out,   32'h0);
        check("rst_done",    done,        32'h0);
        check("rst_illegal", illegal,     32'h0);
        check("rst_rd_en",   rf_rd_en,    32'h0);
        check("rst_ready",   instr_ready, 32'h1);
        check("rst_alu_op",  alu_operation, 32'h0);

        // 0x7F + 1 -> 0x80, negative, no carry; direct load leaves flags alone.
        load(8'h7F);
        check("load_acc",   acc_out,   32'h7F);
        check("load_flags", flags_out, 32'h0);
        send(ALU_SMI, 3'd0, 8'h01, c1);
        drain();
        check("smi_acc",   acc_out,              32'h80);
        check("smi_neg",   flags_out[NEG_FLAG],  32'h1);
        check("smi_carry", flags_out[CARRY_FLAG], 32'h0);

        // Register form: one read cycle, then EXEC with rf data on y.
        load(8'hF0);
        send(ALU_SUM, 3'd2, 8'h00, c1);
        check("sum_read_en",   rf_rd_en,      32'h1);
        check("sum_read_addr", rf_rd_addr,    32'h2);
        check("sum_read_op",   alu_operation, 32'h0);
        @(posedge clock); #1;
        check("sum_exec_rd_en", rf_rd_en,      32'h0);
        check("sum_exec_x",     alu_x,         32'hF0);
        check("sum_exec_y",     alu_y,         32'h20);
        check("sum_exec_op",    alu_operation, {28'h0, ALU_SUM});
        drain();
        check("sum_acc",   acc_out,               32'h10);
        check("sum_carry", flags_out[CARRY_FLAG], 32'h1);
        check("sum_neg",   flags_out[NEG_FLAG],   32'h0);

        // Back-to-back CMI then ANI: no bubble, two retires.
        load(8'h55);
        d0 = n_done;
        send(ALU_CMI, 3'd0, 8'hFF, c1);
        check("cmi_exec_y", alu_y, 32'h0);
        send(ALU_ANI, 3'd0, 8'h0F, c2);
        check("b2b_no_bubble", c2 - c1, 32'd2);
        drain();
        check("b2b_acc",   acc_out,      32'h0A);
        check("b2b_dones", n_done - d0,  32'd2);

        // Undefined opcode: immediate done+illegal, state untouched.
        load(8'h33);
        f_before = flags_out;
        send(4'hF, 3'd0, 8'h00, c1);
        check("ill_ready_next", instr_ready, 32'h1);
        drain();
        check("ill_acc",   acc_out,   32'h33);
        check("ill_flags", flags_out, {28'h0, f_before});

        // XRI to zero.
        load(8'h0F);
        send(ALU_XRI, 3'd0, 8'h0F, c1);
        drain();
        check("xri_acc",  acc_out,              32'h00);
        check("xri_zero", flags_out[ZERO_FLAG], 32'h1);

        // Direct load is ignored during accept and EXEC.
        load(8'h10);
        acc_wr_en   = 1'b1;
        acc_wr_data = 8'hEE;
        send(ALU_SMI, 3'd0, 8'h01, c1);
        @(posedge clock); #1;
        acc_wr_en = 1'b0;
        drain();
        check("wr_ignored_acc", acc_out, 32'h11);

        // Reset during READ aborts the instruction.
        load(8'h44);
        send(ALU_SUM, 3'd2, 8'h00, c1);
        check("abort_in_read", rf_rd_en, 32'h1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        m_acc = '0;
        m_flags = '0;
        check("abort_acc",   acc_out,     32'h0);
        check("abort_flags", flags_out,   32'h0);
        check("abort_ready", instr_ready, 32'h1);
        check("abort_done",  done,        32'h0);
        repeat (4) @(posedge clock);
        #1;

        // Random mix, including undefined opcodes and back-to-back issue.
        for (int i = 0; i < 8; i++) rf_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 40; i++) begin
            send(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)), c1);
        end
        drain();
        check("rand_final_acc",   acc_out,   {24'h0, m_acc});
        check("rand_final_flags", flags_out, {28'h0, m_flags});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_sequencer

// File: doc/alu_sequencer.md
# alu_sequencer

Control FSM that sequences the 8-bit ALU for one instruction at a time. It accepts a decoded ALU instruction over a valid/ready handshake and fetches a register operand from the register file, or uses the instruction's immediate. It then drives the combinational ALU and writes the result into the accumulator and the flags register it owns. It sits between the instruction decoder and the ALU/register file; the accumulator is always the ALU x operand.

## Interface
Parameters:
- `RF_ADDR_W`, default 3: register-file address width (8 registers).

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr_valid`  in  1  decoder offers an instruction.
- `instr_ready`  out  1  sequencer can accept; high only in IDLE.
- `instr_op`  in  4  ALU operation code (`ALU_*` encodings).
- `instr_reg`  in  RF_ADDR_W  source register for register-form ops.
- `instr_imm`  in  8  immediate for immediate-form ops.
- `rf_rd_en`  out  1  register-file read strobe.
- `rf_rd_addr`  out  RF_ADDR_W  read address.
- `rf_rd_data`  in  8  read data, valid the cycle after `rf_rd_en`.
- `alu_x`  out  8  ALU x operand.
- `alu_y`  out  8  ALU y operand.
- `alu_operation`  out  4  ALU operation.
- `alu_out`  in  8  ALU result (combinational).
- `alu_flags`  in  4  ALU flags (combinational).
- `acc_wr_en`  in  1  direct accumulator load.
- `acc_wr_data`  in  8  direct accumulator load value.
- `acc_out`  out  8  accumulator.
- `flags_out`  out  4  flags register.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  one-cycle pulse with `done` for an undefined opcode.

## Operation
- States: IDLE, READ, EXEC.
- IDLE: `instr_ready`=1. On `instr_valid`&`instr_ready`, capture op, reg and imm.
  - Register form (SUM, SB, ANR, ORR, XRR) goes to READ.
  - Immediate form (SMI, SBI, ANI, ORI, XRI) and complement (CM, CMI) go to EXEC.
  - Undefined op stays in IDLE; `done` and `illegal` pulse next cycle; acc and flags unchanged.
- READ: `rf_rd_en`=1, `rf_rd_addr`=captured reg; always moves to EXEC.
- EXEC: `alu_x`=acc, `alu_operation`=captured op, `alu_y`=`rf_rd_data` (register form) or captured imm (immediate form) or 0 (CM/CMI).
  - On the edge leaving EXEC: acc←`alu_out`, flags←`alu_flags`, `done` registered high for the next cycle, state→IDLE.
- Outside EXEC, `alu_operation`, `alu_x` and `alu_y` are driven to 0.
- `acc_wr_en` is honoured only in IDLE when no instruction is accepted that cycle; otherwise it is ignored. A direct load never changes flags.

## Timing
- Reset values: state IDLE, `acc_out`=0, `flags_out`=0, `done`=0, `illegal`=0, `rf_rd_en`=0, `instr_ready`=1 in the cycle after reset.
- Immediate/complement form: accept at edge 0, EXEC in cycle 1, `done` in cycle 2. Register form: READ in cycle 1, EXEC in cycle 2, `done` in cycle 3.
- A new instruction may be accepted in the same cycle `done` is high (back-to-back, no bubble). The updated acc is visible to it.
- Reset asserted in any state aborts the instruction: no acc/flag write, no `done`, registers go to reset values on that edge.
- `instr_ready` is combinational on state only, never on `instr_valid`.

## Configuration
- `ALU_ZERO_FLAG_EN` defined: in EXEC, `flags[ZERO_FLAG]` is written with (`alu_out`==0), overriding whatever the ALU drives on that bit.
- `ALU_ZERO_FLAG_EN` undefined: the zero bit is taken from `alu_flags` unchanged.

## Structure
- Shared package/include: `ALU_*` opcode encodings, `CARRY_FLAG`/`NEG_FLAG`/`ZERO_FLAG` bit indices, state encodings, and decode helpers `is_reg_form` and `is_imm_form`.
- One sub-module: `alu_op_decode`, combinational; classifies `instr_op` as register, immediate, complement or illegal.
- The FSM, operand mux, and accumulator/flags registers stay in the top.

## Test plan
- Reset, then `acc_wr_en` with 0x7F; SMI imm=0x01 → `done` two cycles after accept, acc=0x80, NEG=1, CARRY=0.
- acc=0xF0, R2=0x20; SUM reg=2 → `rf_rd_en` for one cycle with addr 2, `done` three cycles after accept, acc=0x10, CARRY=1, NEG=0.
- acc=0x55; CMI then ANI 0x0F back-to-back → acc=0xAA then 0x0A, no idle cycle between, two `done` pulses.
- Undefined op 0xF with acc=0x33 → `done`+`illegal` pulse, acc stays 0x33, flags unchanged.
- acc=0x0F; XRI 0x0F → acc=0x00, ZERO=1 with `ALU_ZERO_FLAG_EN` defined, ZERO per ALU output without it.
- `reset` asserted during READ of a SUM → no `done`, acc=0, flags=0, `instr_ready`=1 next cycle.
